// File: rtl/mdu_hilo_writer.sv
`default_nettype none
// ============================================================================
// Module      : mdu_hilo_writer
// Description : Iterative multiply/divide unit (MULTU, MULT, DIVU, DIV).
//               Computes one radix-2 step per cycle and writes the result
//               into the HI/LO holding registers with a single-cycle enable.
//               HI/LO storage downstream captures on the falling edge, so
//               hi_out/lo_out are held stable between results.
// Ports       : clk      - system clock, rising-edge state updates
//               rst      - asynchronous active-high reset
//               start    - request pulse, sampled only in IDLE
//               op       - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//               a, b     - rs / rt operands
//               busy     - high while not IDLE
//               hi_out   - product high word / remainder
//               lo_out   - product low word / quotient
//               hi_wena  - HI write enable (one cycle)
//               lo_wena  - LO write enable (always equal to hi_wena)
// Options     : MDU_DIVZERO_FAST_EN - divide by zero bypasses the iterative
//               steps and writes the override result two cycles after start.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_hilo_writer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_wena,
    output logic             lo_wena
);

    localparam int               c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [1:0]           r_op;        // [1]=divide, [0]=signed
    logic [2*WIDTH-1:0]   r_acc;       // {remainder/product-hi, quotient/product-lo}
    logic [WIDTH-1:0]     r_opb;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0]     r_a;         // raw dividend, for the divide-by-zero result
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_res_neg;   // signed op with a[31]^b[31]
    logic                 r_dvd_neg;   // signed op with negative dividend
    logic                 r_divzero;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_in_divzero;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_div_sh;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_step;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    // Operand magnitudes. The most negative value maps to itself, which is
    // its correct magnitude when read as unsigned.
    assign w_a_mag      = (op[0] && a[WIDTH-1]) ? -a : a;
    assign w_b_mag      = (op[0] && b[WIDTH-1]) ? -b : b;
    assign w_in_divzero = op[1] && (b == '0);

    // Shift-add multiply: multiplier sits in the low half and is consumed
    // from bit 0 while the partial product grows into the high half.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: shift the partial remainder left by one, pulling in
    // the next dividend bit; keep the difference only when it did not borrow.
    assign w_div_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_div_sh - {1'b0, r_opb};
    assign w_div_step = w_div_diff[WIDTH]
                      ? {w_div_sh[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b0}
                      : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        w_prod   = r_res_neg ? -r_acc : r_acc;
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_op[1]) begin
            w_fix_lo = r_res_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_fix_hi = r_dvd_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            if (r_divzero) begin
                w_fix_hi = r_a;
                w_fix_lo = '1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef MDU_DIVZERO_FAST_EN
                    // FIX only re-applies the override latched at start.
                    w_state_nxt = w_in_divzero ? S_FIX : S_CALC;
`else
                    w_state_nxt = S_CALC;
`endif
                end
            end
            S_CALC:  if (r_cnt == c_last_step) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_a       <= '0;
            r_cnt     <= '0;
            r_res_neg <= 1'b0;
            r_dvd_neg <= 1'b0;
            r_divzero <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op      <= op;
                        r_a       <= a;
                        r_opb     <= w_b_mag;
                        r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
                        r_cnt     <= '0;
                        r_res_neg <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_dvd_neg <= op[0] & a[WIDTH-1];
                        r_divzero <= w_in_divzero;
`ifdef MDU_DIVZERO_FAST_EN
                        if (w_in_divzero) begin
                            hi_out <= a;
                            lo_out <= '1;
                        end
`endif
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[1] ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    hi_out <= w_fix_hi;
                    lo_out <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign hi_wena = (r_state == S_DONE);
    assign lo_wena = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_hilo_writer
// Description : Directed self-checking bench for mdu_hilo_writer. Each vector
//               carries hand-computed HI/LO results and the expected cycle
//               position of the write enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_hilo_writer;

    localparam int c_lat = 34;
`ifdef MDU_DIVZERO_FAST_EN
    localparam int c_dz_lat = 2;
`else
    localparam int c_dz_lat = 34;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        hi_wena;
    logic        lo_wena;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_hilo_writer #(.WIDTH(32)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .hi_out  (hi_out),
        .lo_out  (lo_out),
        .hi_wena (hi_wena),
        .lo_wena (lo_wena)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and watch it to completion. repulse>0 pulses start
    // again with other operands at that cycle after the accepted start.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] ai, input logic [31:0] bi,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat, input int repulse);
        int          n_busy  = 0;
        int          n_wena  = 0;
        int          n_split = 0;
        int          wena_at = -1;
        logic [31:0] got_hi  = '0;
        logic [31:0] got_lo  = '0;
        @(negedge clk);
        op = o; a = ai; b = bi; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'b00; a = '0; b = '0;
        for (int k = 1; k <= exp_lat + 6; k++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (hi_wena !== lo_wena) n_split++;
            if (hi_wena) begin
                n_wena++;
                wena_at = k;
                got_hi  = hi_out;
                got_lo  = lo_out;
            end
            if (k == repulse) begin
                start = 1'b1; op = ~o; a = 32'h5555_5555; b = 32'h0000_0003;
            end else if (k == repulse + 1) begin
                start = 1'b0; op = 2'b00; a = '0; b = '0;
            end
        end
        check({tag, " hi"},        64'(got_hi),  64'(exp_hi));
        check({tag, " lo"},        64'(got_lo),  64'(exp_lo));
        check({tag, " wena cnt"},  64'(n_wena),  64'd1);
        check({tag, " wena cyc"},  64'(wena_at), 64'(exp_lat));
        check({tag, " busy cyc"},  64'(n_busy),  64'(exp_lat));
        check({tag, " split"},     64'(n_split), 64'd0);
        check({tag, " hold"},      {hi_out, lo_out}, {exp_hi, exp_lo});
    endtask

    initial begin
        int n_late_wena;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset busy",   64'(busy),    64'd0);
        check("reset hiwena", 64'(hi_wena), 64'd0);
        check("reset lowena", 64'(lo_wena), 64'd0);
        check("reset hilo",   {hi_out, lo_out}, 64'd0);
        rst = 1'b0;

        run_op("multu max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, c_lat, 0);
        run_op("mult -3*5",  2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, c_lat, 0);
        run_op("mult min^2", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, c_lat, 0);
        run_op("divu 7/2",   2'b10, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, c_lat, 0);
        run_op("div -7/2",   2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, c_lat, 0);
        run_op("div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, c_lat, 0);
        run_op("divu dz",    2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, c_dz_lat, 0);
        run_op("div dz neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, c_dz_lat, 0);
        run_op("mult repls", 2'b01, 32'h0000_0006, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, c_lat, 5);
        run_op("div 7/-2",   2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, c_lat, 0);

        // Abort a divide mid-flight; outputs must clear at once, no write after.
        @(negedge clk);
        op = 2'b11; a = 32'h0000_0064; b = 32'h0000_0007; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy",   64'(busy),    64'd0);
        check("abort hiwena", 64'(hi_wena), 64'd0);
        check("abort lowena", 64'(lo_wena), 64'd0);
        check("abort hilo",   {hi_out, lo_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_late_wena = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hi_wena || lo_wena || busy) n_late_wena++;
        end
        check("abort no write", 64'(n_late_wena), 64'd0);

        run_op("multu 3*4",  2'b00, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, c_lat, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
